// File: rtl/ram_bus_ctrl.sv
// Single-port RAM bus controller: one request at a time, one-cycle writes,
// two-cycle reads with a turnaround cycle so the shared data bus never contends.
module ram_bus_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_add,
    inout  wire  [DATA_W-1:0] ram_data
);

    // state   | meaning
    // IDLE    | ready for a request, RAM deselected
    // WRITE   | write strobes and write data on the bus for one cycle
    // RD_ADDR | read address presented, bus released to the RAM
    // RD_DATA | read held, RAM data captured at the closing edge
    // TURN    | RAM deselected for bus turnaround, response pulse
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_DATA = 3'd3;
    localparam logic [2:0] TURN    = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              handshake;

    assign req_ready = (state == IDLE);
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_nxt = req_wr ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (state == RD_DATA);
            if (handshake) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD_DATA) begin
                rsp_rdata <= ram_data;
            end
        end
    end

    // RAM-side outputs come only from registered state so request inputs
    // can never glitch the bus.
    assign ram_cs   = (state == WRITE) || (state == RD_ADDR) || (state == RD_DATA);
    assign ram_wr   = (state == WRITE);
    assign ram_add  = addr_q;
    assign busy     = (state != IDLE);
    assign ram_data = (state == WRITE) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Randomized self-checking bench for ram_bus_ctrl with an attached RAM model
// and a per-operation reference of expected bus activity and read data.
module tb_ram_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ram_cs;
    logic       ram_wr;
    logic [3:0] ram_add;
    wire  [7:0] ram_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram_mem   [16];
    logic [7:0] model_mem [16];
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    ram_bus_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ram_cs    (ram_cs),
        .ram_wr    (ram_wr),
        .ram_add   (ram_add),
        .ram_data  (ram_data)
    );

    // Asynchronous-read RAM on the shared bus.
    assign ram_data = (ram_cs && !ram_wr) ? ram_mem[ram_add] : 8'bz;

    always @(posedge clk) begin
        if (ram_cs && ram_wr) ram_mem[ram_add] <= ram_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: during a read the bus must carry exactly the RAM's word.
    always @(negedge clk) begin
        if (ram_cs === 1'b1 && ram_wr === 1'b0) begin
            check_val("bus_rd_clean", {31'd0, $isunknown(ram_data)}, 32'd0);
            check_val("bus_rd_value", {24'd0, ram_data}, {24'd0, ram_mem[ram_add]});
        end
        if (ram_cs === 1'b1 && ram_wr === 1'b1)
            check_val("bus_wr_known", {31'd0, $isunknown(ram_data)}, 32'd0);
    end

    task automatic wait_ready();
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("accept_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle.
    task automatic do_op(input bit wr, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] exp;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        wait_ready();
        @(posedge clk);
        #1;
        scramble_req();
        if (wr) begin
            @(negedge clk);
            check_val("wr_cs",    {31'd0, ram_cs}, 32'd1);
            check_val("wr_we",    {31'd0, ram_wr}, 32'd1);
            check_val("wr_add",   {28'd0, ram_add}, {28'd0, a});
            check_val("wr_data",  {24'd0, ram_data}, {24'd0, d});
            check_val("wr_ready", {31'd0, req_ready}, 32'd0);
            check_val("wr_busy",  {31'd0, busy}, 32'd1);
            model_mem[a] = d;
            @(negedge clk);
            check_val("wr_done_ready", {31'd0, req_ready}, 32'd1);
            check_val("wr_done_cs",    {31'd0, ram_cs}, 32'd0);
            check_val("wr_keep_rdata", {24'd0, rsp_rdata}, {24'd0, last_rd});
        end else begin
            exp = model_mem[a];
            @(negedge clk);
            check_val("rd1_cs",    {31'd0, ram_cs}, 32'd1);
            check_val("rd1_we",    {31'd0, ram_wr}, 32'd0);
            check_val("rd1_add",   {28'd0, ram_add}, {28'd0, a});
            check_val("rd1_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            check_val("rd2_cs",    {31'd0, ram_cs}, 32'd1);
            check_val("rd2_valid", {31'd0, rsp_valid}, 32'd0);
            check_val("rd2_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check_val("rd3_cs",    {31'd0, ram_cs}, 32'd0);
            check_val("rd3_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("rd3_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
            check_val("rd3_busy",  {31'd0, busy}, 32'd1);
            check_val("rd3_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check_val("rd4_valid", {31'd0, rsp_valid}, 32'd0);
            check_val("rd4_ready", {31'd0, req_ready}, 32'd1);
            check_val("rd4_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
            last_rd = exp;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old7;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i]   = 8'($urandom);
            model_mem[i] = ram_mem[i];
        end
        last_rd = 8'd0;
        rst = 1'b1;
        scramble_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_state_cs",    {31'd0, ram_cs}, 32'd0);
        check_val("rst_state_we",    {31'd0, ram_wr}, 32'd0);
        check_val("rst_state_add",   {28'd0, ram_add}, 32'd0);
        check_val("rst_state_busy",  {31'd0, busy}, 32'd0);
        check_val("rst_state_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_state_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_state_rdata", {24'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back one location.
        do_op(1'b1, 4'd3, 8'hA5);
        do_op(1'b0, 4'd3, 8'h00);

        // Fill every address, then read all back.
        for (int i = 0; i < 16; i++) do_op(1'b1, 4'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 16; i++) do_op(1'b0, 4'(i), 8'h00);

        // Random mix.
        for (int i = 0; i < 60; i++) do_op(1'($urandom), 4'($urandom), 8'($urandom));

        // Read held straight into a write on the same address.
        old7 = model_mem[7];
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd7; req_wdata = 8'h00;
        wait_ready();
        @(posedge clk);
        #1;
        req_wr = 1'b1; req_wdata = 8'h11;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_val("hold_ready_low", {31'd0, req_ready}, 32'd0);
        end
        check_val("hold_rd_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("hold_rd_old",   {24'd0, rsp_rdata}, {24'd0, old7});
        last_rd = old7;
        @(negedge clk);
        check_val("hold_ready_back", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        scramble_req();
        @(negedge clk);
        check_val("hold_wr_cs",   {31'd0, ram_cs}, 32'd1);
        check_val("hold_wr_we",   {31'd0, ram_wr}, 32'd1);
        check_val("hold_wr_data", {24'd0, ram_data}, 32'h11);
        model_mem[7] = 8'h11;
        @(negedge clk);
        do_op(1'b0, 4'd7, 8'h00);

        // Reset during RD_DATA aborts the read.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd9;
        wait_ready();
        @(posedge clk);
        #1;
        scramble_req();
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_rd", {31'd0, ram_cs}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("abort_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_val("abort_ready", {31'd0, req_ready}, 32'd1);
        check_val("abort_cs",    {31'd0, ram_cs}, 32'd0);
        last_rd = 8'd0;
        @(negedge clk);
        check_val("abort_no_late_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset together with a request: nothing accepted.
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd5; req_wdata = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        scramble_req();
        @(negedge clk);
        check_val("rst_req_cs1", {31'd0, ram_cs}, 32'd0);
        @(negedge clk);
        check_val("rst_req_cs2", {31'd0, ram_cs}, 32'd0);
        do_op(1'b0, 4'd5, 8'h00);

        // Reset during WRITE: the write still lands.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd12; req_wdata = 8'hC3;
        wait_ready();
        @(posedge clk);
        #1;
        scramble_req();
        @(negedge clk);
        check_val("rst_wr_cs", {31'd0, ram_cs & ram_wr}, 32'd1);
        rst = 1'b1;
        model_mem[12] = 8'hC3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 8'd0;
        @(negedge clk);
        check_val("rst_wr_idle", {31'd0, req_ready}, 32'd1);
        do_op(1'b0, 4'd12, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
